// File: rtl/ser_data_receiver.sv
// 8N1 serial receiver: double-flop synchronizer, mid-bit sampling FSM, and
// registered byte/strobe outputs. Bit period is given in clock cycles.
module ser_data_receiver #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       rx_done,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    logic          sync1_q;
    logic          rx_s_q;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    sh_q, sh_d;
    logic [7:0]    data_q, data_d;
    logic          rx_done_q, rx_done_d;
    logic          frame_err_q, frame_err_d;
    logic          busy_q, busy_d;

    // Two-flop synchronizer; both stages reset to the idle line level
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= rx;
            rx_s_q  <= sync1_q;
        end
    end

    // Next-state, datapath and output strobe computation
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        sh_d        = sh_q;
        data_d      = data_q;
        rx_done_d   = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) begin
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    idx_d = 3'd0;
                    // A line that is high again at mid start bit was only a glitch
                    if (!rx_s_q) begin
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DATA: begin
                if (cnt_q == BIT_M1) begin
                    cnt_d       = '0;
                    sh_d[idx_q] = rx_s_q;
                    if (idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_STOP: begin
                if (cnt_q == BIT_M1) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        data_d    = sh_q;
                        rx_done_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_BREAK: begin
                // Hold here until the line returns high so a break is not
                // decoded as a stream of zero bytes
                cnt_d = '0;
                if (rx_s_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BREAK;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                idx_d   = 3'd0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Control and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= 3'd0;
            sh_q        <= 8'h00;
            data_q      <= 8'h00;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            sh_q        <= sh_d;
            data_q      <= data_d;
            rx_done_q   <= rx_done_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
        end
    end

    assign data      = data_q;
    assign rx_done   = rx_done_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_ser_data_receiver.sv
// Directed and randomized bench for ser_data_receiver; an ideal 8N1 source
// feeds rx and a byte-level expectation queue is compared with captured strobes.
module tb_ser_data_receiver;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] data;
    logic       rx_done;
    logic       frame_err;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int ferr_cnt = 0;
    int exp_ferr = 0;
    bit both_seen = 1'b0;
    logic [7:0] last_good = 8'h00;

    logic [7:0] got_q[$];
    int         got_t[$];
    logic [7:0] exp_q[$];

    ser_data_receiver #(.CLKS_PER_BIT(CPB)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .data     (data),
        .rx_done  (rx_done),
        .frame_err(frame_err),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every strobe with the cycle it was observed in
    always @(negedge clk) begin
        if (rx_done) begin
            got_q.push_back(data);
            got_t.push_back(cyc);
        end
        if (frame_err) ferr_cnt = ferr_cnt + 1;
        if (rx_done && frame_err) both_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks = checks + 1;
        assert (obs === exp_v) else begin
            errors = errors + 1;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic line_for(input logic lvl, input int n);
        rx = lvl;
        repeat (n) @(negedge clk);
    endtask

    // Ideal 8N1 source; records what the receiver ought to report
    task automatic send_frame(input logic [7:0] b, input logic stop_ok, output int t_start);
        t_start = cyc;
        line_for(1'b0, CPB);
        for (int i = 0; i < 8; i++) line_for(b[i], CPB);
        line_for(stop_ok, CPB);
        if (stop_ok) begin
            exp_q.push_back(b);
            last_good = b;
        end else begin
            exp_ferr = exp_ferr + 1;
        end
    endtask

    task automatic cmp_all(input string tag);
        #1;
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk({tag, "_byte"}, got_q[i], exp_q[i]);
        chk({tag, "_data"}, data, last_good);
        chk({tag, "_ferr"}, ferr_cnt, exp_ferr);
        got_q.delete();
        got_t.delete();
        exp_q.delete();
    endtask

    initial begin
        int ts;
        int ts2;
        logic [7:0] singles [3];
        singles[0] = 8'h0F;
        singles[1] = 8'hAA;
        singles[2] = 8'hEE;

        rst = 1'b1;
        rx  = 1'b1;
        repeat (10) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("reset_data", data, 8'h00);
        chk("reset_done", rx_done, 1'b0);
        chk("reset_ferr", frame_err, 1'b0);
        chk("reset_busy", busy, 1'b0);
        line_for(1'b1, 200);
        chk("idle_busy", busy, 1'b0);
        cmp_all("idle");

        // Single frames with latency check
        for (int k = 0; k < 3; k++) begin
            send_frame(singles[k], 1'b1, ts);
            line_for(1'b1, 5 * CPB);
            #1;
            chk("single_count", got_t.size(), 1);
            if (got_t.size() == 1)
                chk("single_latency_ok", ((got_t[0] - ts) >= 154 && (got_t[0] - ts) <= 156), 1'b1);
            cmp_all("single");
        end

        // Back-to-back frames with no idle gap
        send_frame(8'h55, 1'b1, ts);
        send_frame(8'h81, 1'b1, ts2);
        line_for(1'b1, 5 * CPB);
        #1;
        chk("b2b_count", got_t.size(), 2);
        if (got_t.size() == 2)
            chk("b2b_spacing", got_t[1] - got_t[0], 160);
        cmp_all("b2b");

        // Glitch shorter than half a bit
        line_for(1'b0, 4);
        #1;
        chk("glitch_busy_high", busy, 1'b1);
        line_for(1'b1, HALF + 3);
        #1;
        chk("glitch_busy_low", busy, 1'b0);
        line_for(1'b1, 3 * CPB);
        cmp_all("glitch");

        // Framing error followed by a held-low break
        send_frame(8'h3C, 1'b0, ts);
        line_for(1'b0, 40);
        #1;
        chk("break_busy", busy, 1'b1);
        cmp_all("break_low");
        line_for(1'b1, CPB);
        #1;
        chk("break_exit_busy", busy, 1'b0);
        send_frame(8'h12, 1'b1, ts);
        line_for(1'b1, 5 * CPB);
        cmp_all("after_break");

        // Reset pulse in the middle of bit 4 of 0xFF
        line_for(1'b0, CPB);
        line_for(1'b1, 4 * CPB + HALF);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_good = 8'h00;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_data", data, 8'h00);
        line_for(1'b1, 4 * CPB);
        cmp_all("midrst");
        send_frame(8'h33, 1'b1, ts);
        line_for(1'b1, 5 * CPB);
        cmp_all("post_rst");

        // Random bytes with random inter-frame gaps
        for (int k = 0; k < 12; k++) begin
            send_frame(8'($urandom_range(0, 255)), 1'b1, ts);
            line_for(1'b1, CPB * $urandom_range(0, 2));
        end
        line_for(1'b1, 5 * CPB);
        cmp_all("random");

        chk("mutual_exclusion", both_seen, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
